// File: rtl/tank_sensor_emulator_if.sv
`default_nettype none
// ============================================================================
// Module      : tank_sensor_emulator_if
// Description : Control/status bundle of the tank sensor emulator.
//               master : the controller side (bench, bring-up host)
//               slave  : the emulator itself
//               Signals:
//                 fill / drain          level-sensitive motion requests
//                 load_valid/level/ready seek handshake and target
//                 fault_load/sel/mode   fault injection strobe and setting
//                 sensors_out           8-bit thermometer sensor bus
//                 level / full / empty  simulated level and its limits
// Revision    : 1.0 - initial release
// ============================================================================
interface tank_sensor_emulator_if;
    logic       fill;
    logic       drain;
    logic       load_valid;
    logic [7:0] load_level;
    logic       load_ready;
    logic       fault_load;
    logic [2:0] fault_sel;
    logic [1:0] fault_mode;
    logic [7:0] sensors_out;
    logic [7:0] level;
    logic       full;
    logic       empty;

    modport master (
        output fill, drain, load_valid, load_level,
        output fault_load, fault_sel, fault_mode,
        input  load_ready, sensors_out, level, full, empty
    );

    modport slave (
        input  fill, drain, load_valid, load_level,
        input  fault_load, fault_sel, fault_mode,
        output load_ready, sensors_out, level, full, empty
    );
endinterface
`default_nettype wire

// File: rtl/tank_sensor_emulator.sv
`default_nettype none
// ============================================================================
// Module      : tank_sensor_emulator
// Description : Simulated liquid level driving an 8-bit thermometer-coded
//               level-sensor bus. The level fills, drains or seeks to a
//               commanded target, one unit per prescaler tick.
//               Optional fault injection (compile macro SENSOR_FAULT_EN)
//               forces one sensor bit stuck-0, stuck-1 or inverted.
// Ports       : clk_100MHz  single clock
//               reset_n     asynchronous active-low reset
//               bus         tank_sensor_emulator_if.slave (controls, status)
// Parameters  : TICK_DIV         clock cycles per level step (>= 2)
//               STEPS_PER_SENSOR level units between sensors (1..28)
// Revision    : 1.0 - initial release
// ============================================================================
module tank_sensor_emulator #(
    parameter int TICK_DIV         = 100000,
    parameter int STEPS_PER_SENSOR = 16
) (
    input  logic                         clk_100MHz,
    input  logic                         reset_n,
    tank_sensor_emulator_if.slave        bus
);

    localparam int              c_pw        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_pw-1:0] c_tick_last = c_pw'(TICK_DIV - 1);
    localparam logic [7:0]      c_level_max = 8'(9 * STEPS_PER_SENSOR - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_DRAIN = 2'd2,
        S_SEEK  = 2'd3
    } state_t;

    state_t          r_state;
    logic [c_pw-1:0] r_presc;
    logic [7:0]      r_level;
    logic [7:0]      r_target;
    logic            r_load_ready;
    logic [7:0]      r_sensors;

    logic            w_tick;
    logic            w_accept;
    logic            w_fill_only;
    logic            w_drain_only;
    logic [7:0]      w_target;
    logic [7:0]      w_clean;
    logic [7:0]      w_sens_next;

    assign w_tick       = (r_presc == c_tick_last);
    assign w_accept     = bus.load_valid & r_load_ready;
    assign w_fill_only  = bus.fill & ~bus.drain;
    assign w_drain_only = bus.drain & ~bus.fill;
    assign w_target     = (bus.load_level > c_level_max) ? c_level_max : bus.load_level;

    // Free-running prescaler; its phase never depends on the FSM.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + c_pw'(1);
        end
    end

    // Level FSM. A seek request wins over fill/drain in every non-SEEK state.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_level      <= 8'd0;
            r_target     <= 8'd0;
            r_load_ready <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_target     <= w_target;
                        r_state      <= S_SEEK;
                        r_load_ready <= 1'b0;
                    end else if (w_fill_only) begin
                        r_state <= S_FILL;
                    end else if (w_drain_only) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_FILL: begin
                    if (w_accept) begin
                        r_target     <= w_target;
                        r_state      <= S_SEEK;
                        r_load_ready <= 1'b0;
                    end else if (!w_fill_only) begin
                        r_state <= S_IDLE;
                    end else if (w_tick && (r_level != c_level_max)) begin
                        r_level <= r_level + 8'd1;
                    end
                end
                S_DRAIN: begin
                    if (w_accept) begin
                        r_target     <= w_target;
                        r_state      <= S_SEEK;
                        r_load_ready <= 1'b0;
                    end else if (!w_drain_only) begin
                        r_state <= S_IDLE;
                    end else if (w_tick && (r_level != 8'd0)) begin
                        r_level <= r_level - 8'd1;
                    end
                end
                S_SEEK: begin
                    // Arrival is checked before stepping, so a target equal to
                    // the current level exits on the next cycle with no tick.
                    if (r_level == r_target) begin
                        r_state      <= S_IDLE;
                        r_load_ready <= 1'b1;
                    end else if (w_tick) begin
                        if (r_target > r_level) begin
                            r_level <= r_level + 8'd1;
                        end else begin
                            r_level <= r_level - 8'd1;
                        end
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_load_ready <= 1'b1;
                end
            endcase
        end
    end

    // Clean thermometer code: sensor i is wet once level reaches (i+1) steps.
    for (genvar gi = 0; gi < 8; gi++) begin : g_clean
        localparam logic [7:0] c_thresh = 8'((gi + 1) * STEPS_PER_SENSOR);
        assign w_clean[gi] = (r_level >= c_thresh);
    end

`ifdef SENSOR_FAULT_EN
    logic [2:0] r_fault_sel;
    logic [1:0] r_fault_mode;

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_fault_sel  <= 3'd0;
            r_fault_mode <= 2'b00;
        end else if (bus.fault_load) begin
            r_fault_sel  <= bus.fault_sel;
            r_fault_mode <= bus.fault_mode;
        end
    end

    always_comb begin
        w_sens_next = w_clean;
        case (r_fault_mode)
            2'b01:   w_sens_next[r_fault_sel] = 1'b0;
            2'b10:   w_sens_next[r_fault_sel] = 1'b1;
            2'b11:   w_sens_next[r_fault_sel] = ~w_clean[r_fault_sel];
            default: w_sens_next = w_clean;
        endcase
    end
`else
    // Fault controls are accepted on the bus but have no effect in this build.
    wire w_unused_fault = ^{bus.fault_load, bus.fault_sel, bus.fault_mode};

    assign w_sens_next = w_clean;
`endif

    // Registered sensor bus: lags level by one cycle.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_sensors <= 8'h00;
        end else begin
            r_sensors <= w_sens_next;
        end
    end

    assign bus.sensors_out = r_sensors;
    assign bus.level       = r_level;
    assign bus.load_ready  = r_load_ready;
    assign bus.full        = (r_level == c_level_max);
    assign bus.empty       = (r_level == 8'd0);

endmodule
`default_nettype wire

// File: doc/tank_sensor_emulator.md
# tank_sensor_emulator

- Generates the 8-bit thermometer-coded level-sensor bus that the meter's sensor input stage consumes, driven by an internal simulated liquid level.
- The level fills, drains, or seeks to a commanded target at a prescaled rate.
- Used for board bring-up and closed-loop regression: its `sensors_out` connects to the meter's `sensors_input` pins.
- Optional fault injection produces illegal codes to exercise the meter's input-error path.

## Interface
Parameters:
- `TICK_DIV`, default 100000 — clock cycles per level step (1 kHz at 100 MHz); legal range ≥ 2.
- `STEPS_PER_SENSOR`, default 16 — level units between adjacent sensors; legal range 1..28.
  - `LEVEL_MAX` = 9·`STEPS_PER_SENSOR` − 1 (143 at default).

Ports:
- `clk_100MHz` in 1 — single clock; all logic in this domain.
- `reset_n` in 1 — asynchronous, active-low reset.
- `fill` in 1 — level-sensitive; raise level one unit per tick.
- `drain` in 1 — level-sensitive; lower level one unit per tick.
- `load_valid` in 1 — seek request.
- `load_level` in 8 — seek target.
- `load_ready` out 1 — emulator can accept a seek.
- `fault_load` in 1 — single-cycle strobe; latches `fault_sel`/`fault_mode`.
- `fault_sel` in 3 — sensor bit index to corrupt.
- `fault_mode` in 2 — 00 none, 01 stuck-0, 10 stuck-1, 11 inverted.
- `sensors_out` out 8 — thermometer code; bit i is sensor i (bit 0 = lowest).
- `level` out 8 — current simulated level.
- `full` out 1 — `level` == `LEVEL_MAX`.
- `empty` out 1 — `level` == 0.

## Operation
- Prescaler counts 0..`TICK_DIV`−1 free-running; `tick` is asserted for one cycle when count == `TICK_DIV`−1. Level changes only on tick cycles.
- FSM states:
  - IDLE — no motion; `load_ready`=1.
  - FILL — entered from IDLE when `fill` & !`drain`.
  - DRAIN — entered from IDLE when `drain` & !`fill`.
  - SEEK — `load_ready`=0.
- IDLE→SEEK on `load_valid` & `load_ready`; seek has priority over fill/drain.
  - Accepted target is captured as min(`load_level`, `LEVEL_MAX`).
  - In FILL/DRAIN, `load_ready`=1 and an accepted load moves directly to SEEK.
- FILL/DRAIN→IDLE when the controlling input deasserts or both `fill` and `drain` are high. Simultaneous `fill` and `drain` give no motion.
- FILL saturates at `LEVEL_MAX`; DRAIN saturates at 0. No wrap-around; state persists while saturated.
- SEEK steps ±1 per tick toward the target and returns to IDLE on the cycle `level` equals the target. A target equal to the current level returns to IDLE on the next cycle with no tick consumed.
- Clean code: bit i = (`level` ≥ (i+1)·`STEPS_PER_SENSOR`).
- Fault register (sel, mode) resets to mode 00. `fault_load` overwrites it; a fault persists until reloaded or reset.
- `sensors_out` = clean code with the fault applied to bit `fault_sel`.

## Timing
- Reset values (asynchronous on `reset_n` low):
  - `level`=0, `sensors_out`=8'h00, `empty`=1, `full`=0, `load_ready`=1.
  - FSM=IDLE, prescaler=0, fault cleared.
- `level`, `full` and `empty` update on the clock edge ending a tick cycle.
- `sensors_out` is registered from `level`: it lags `level` by exactly 1 cycle.
- A fault takes effect on `sensors_out` 1 cycle after the `fault_load` edge.
- `load_ready` drops on the cycle after acceptance and rises on the cycle SEEK exits.
- Reset asserted mid-SEEK abandons the target; no pending request survives reset.
- Prescaler phase is unaffected by FSM transitions.

## Configuration
- `SENSOR_FAULT_EN`:
  - Defined: fault register and masking logic are compiled in, as described above.
  - Undefined: `fault_load`, `fault_sel` and `fault_mode` are present but ignored; `sensors_out` is always the clean code; no fault register is synthesized.

## Test plan
All scenarios use `TICK_DIV`=4, `STEPS_PER_SENSOR`=2 (`LEVEL_MAX`=17).
- Reset then idle 20 cycles -> `level`=0, `sensors_out`=00, `empty`=1, `load_ready`=1.
- Hold `fill` 2 ticks -> `level`=2, `sensors_out`=8'b0000_0001 one cycle later.
  - Continue filling 30 ticks -> `level`=17, `full`=1, `sensors_out`=FF, no wrap.
- From 17, load 5 -> `load_ready` low for 12 ticks, then `level`=5, `sensors_out`=8'b0000_0011, `load_ready`=1.
  - Load 200 from 5 -> seeks to 17.
- `fill` and `drain` both high for 10 ticks at level 8 -> `level` stays 8.
- `SENSOR_FAULT_EN` defined, level 0, `fault_load` with sel=5, mode=10 -> `sensors_out`=8'b0010_0000.
  - Same stimulus with the macro undefined -> `sensors_out`=00.
- Assert `reset_n` low mid-SEEK (level 9 → target 1) -> all outputs at reset values immediately.
  - After release, level stays 0 with no further seek.
